fifo_byte_serializer: RTL
=========================

# fifo_byte_serializer

Downstream drain stage for the team's word FIFO. It pops one DATA_W-bit word from the FIFO read interface and emits it as DATA_W/BYTE_W bytes on a valid/ready byte stream, marking the last byte of each word. Successive words are sent back-to-back with no bubble when the FIFO stays non-empty and the sink stays ready.

## Interface
- DATA_W, 32, FIFO word width; must be an integer multiple of BYTE_W, at least 2×BYTE_W
- BYTE_W, 8, output beat width
- MSB_FIRST, 0, 0: byte 0 = bits [BYTE_W-1:0] sent first; 1: top byte sent first
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- fifo_rdata_i  in  DATA_W  FIFO head word; show-ahead, valid whenever fifo_empty_i=0
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rd_en_o  out  1  pop request; FIFO pops at the clock edge when high and not empty
- flush_i  in  1  synchronous abort of the word in flight
- m_data_o  out  BYTE_W  output byte
- m_valid_o  out  1  output byte valid
- m_ready_i  in  1  sink accepts byte
- m_last_o  out  1  m_data_o is final byte of current word
- busy_o  out  1  word in flight (equals m_valid_o)

## Operation
- NBYTES = DATA_W/BYTE_W. Byte counter width = $clog2(NBYTES). Counter runs 0..NBYTES-1 and does not wrap past the last byte.
- Two states:
  - IDLE: m_valid_o=0.
  - SEND: m_valid_o=1, holds a word in the shift register.
- Load condition (load) = !fifo_empty_i && !flush_i && (IDLE || (SEND && m_ready_i && m_last_o)).
- fifo_rd_en_o = load. It is combinational, never high when fifo_empty_i=1, and forced 0 while reset_i=1.
- On load: capture fifo_rdata_i into the shift register, clear the counter, go to (or stay in) SEND.
- Handshake: a byte transfers when m_valid_o && m_ready_i.
  - Non-last byte: shift by BYTE_W toward the output end, increment the counter.
  - Last byte without load: go to IDLE.
- m_data_o holds the output end of the shift register: low byte if MSB_FIRST=0, high byte if MSB_FIRST=1.
- m_last_o = SEND && counter==NBYTES-1.
- While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable. Valid is never withdrawn except by flush_i or reset.
- flush_i has priority over everything:
  - Next state IDLE, counter cleared, no pop that cycle.
  - The word in flight is discarded. FIFO contents are untouched.
- Sink readiness never gates the pop of the first word from IDLE.

## Timing
- Reset values (async assert, sync to clk_i on deassert): state IDLE, m_valid_o=0, m_last_o=0, m_data_o=0, busy_o=0, counter=0, shift register=0.
- Latency: word present at FIFO head while IDLE → first byte valid on the next cycle (1 clk).
- Throughput: 1 byte/clk with m_ready_i held high. A word occupies exactly NBYTES cycles; next word's first byte follows the previous last byte with zero gap.
- Empty FIFO when the last byte is accepted → IDLE next cycle, m_valid_o=0.
- Reset mid-word: the in-flight word is lost. The FIFO is reset separately by the integrator.
- flush_i coinciding with last-byte acceptance: the byte counts as transferred, no pop, IDLE.

## Structure
- Package fifo_ser_pkg holds:
  - state enum (ST_IDLE, ST_SEND)
  - default DATA_W/BYTE_W localparams
  - function bytes_per_word()
- Single module, no sub-module. The shift register, counter and FSM are small enough to stay inline.
- Static assertion that DATA_W % BYTE_W == 0.

## Test plan
- Reset with FIFO holding 0xA1B2C3D4, MSB_FIRST=0, ready high:
  - all outputs 0 during reset
  - after release: pop pulse, then bytes D4,C3,B2,A1 on consecutive cycles, m_last_o on A1.
- Two words 0x11223344, 0x55667788 queued, ready high:
  - 8 consecutive valid beats, no gap
  - exactly 2 pops; the second pop is coincident with acceptance of byte 11.
- Ready toggling 1,0,0,1 on word 0xDEADBEEF:
  - EF transfers
  - BE holds stable for 2 cycles
  - no extra pop; remaining order intact.
- flush_i asserted after 2 bytes of 0xCAFEF00D:
  - m_valid_o=0 next cycle
  - next word from the FIFO starts at its byte 0
  - 0xCAFEF00D is not resent.
- MSB_FIRST=1, word 0x01020304: bytes 01,02,03,04, last on 04.
- FIFO empty throughout: fifo_rd_en_o never high, m_valid_o stays 0. Random empty/ready stress matches a scoreboard byte-for-byte.

Source files
------------

// File: rtl/fifo_ser_pkg.sv
// Shared types and defaults for the FIFO word-to-byte serializer.
//   ser_state_e      : serializer FSM states
//   DEF_DATA_W/BYTE_W: default word / beat widths
//   bytes_per_word() : number of beats per FIFO word
package fifo_ser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BYTE_W = 8;

    function automatic int unsigned bytes_per_word(input int unsigned data_w,
                                                   input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drain stage for a show-ahead word FIFO: pops one DATA_W word and streams it out as
// DATA_W/BYTE_W beats on a valid/ready interface, flagging the final beat of each word.
// Words follow each other with no bubble while the FIFO is non-empty and the sink ready.
// Ports:
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   fifo_rdata_i          : FIFO head word (valid while fifo_empty_i=0)
//   fifo_empty_i          : FIFO empty flag
//   fifo_rd_en_o          : pop request (combinational)
//   flush_i               : synchronous abort of the word in flight
//   m_data_o/m_valid_o    : output beat and its valid
//   m_ready_i             : sink accepts beat
//   m_last_o              : current beat is the last of its word
//   busy_o                : word in flight
module fifo_byte_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BYTE_W    = DEF_BYTE_W,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] fifo_rdata_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic              flush_i,
    output logic [BYTE_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o
);

    localparam int unsigned      NBYTES   = bytes_per_word(DATA_W, BYTE_W);
    localparam int unsigned      CNT_W    = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    if (((DATA_W % BYTE_W) != 0) || (DATA_W < 2 * BYTE_W)) begin : g_bad_width
        $error("DATA_W must be a multiple of BYTE_W and at least 2*BYTE_W");
    end

    ser_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              sending;
    logic              last_beat;
    logic              load;

    assign sending   = (state_q == ST_SEND);
    assign last_beat = sending && (cnt_q == CNT_LAST);

    // Reload either from idle or on the very edge the last beat leaves, so consecutive
    // words are gapless. Sink readiness does not matter when starting from idle.
    assign load = !reset_i && !fifo_empty_i && !flush_i &&
                  (!sending || (m_ready_i && last_beat));

    assign fifo_rd_en_o = load;
    assign m_valid_o    = sending;
    assign busy_o       = sending;
    assign m_last_o     = last_beat;
    assign m_data_o     = MSB_FIRST ? sreg_q[DATA_W-1 -: BYTE_W] : sreg_q[BYTE_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        if (flush_i) begin
            // Drop the word in flight; the shift register is not visible while idle.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (load) begin
            state_d = ST_SEND;
            cnt_d   = '0;
            sreg_d  = fifo_rdata_i;
        end else begin
            unique case (state_q)
                ST_SEND: begin
                    if (m_ready_i) begin
                        if (last_beat) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d  = cnt_q + CNT_W'(1);
                            sreg_d = MSB_FIRST ? (sreg_q << BYTE_W) : (sreg_q >> BYTE_W);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule
